// File: rtl/counter_sched.sv
// Write-port scheduler for the 3-channel Counter: round-robin between CPU and aux requesters,
// control word then lock value per request, plus a synchronised, sticky counter0 edge irq.
module counter_sched #(
   parameter int unsigned SETTLE_CYC  = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic [1:0]  cpu_ch,
   input  logic [1:0]  cpu_mode,
   input  logic [31:0] cpu_val,
   output logic        cpu_done,
   input  logic        aux_req,
   input  logic [1:0]  aux_ch,
   input  logic [1:0]  aux_mode,
   input  logic [31:0] aux_val,
   output logic        aux_done,
   output logic        counter_we,
   output logic [1:0]  counter_ch,
   output logic [31:0] counter_val,
   input  logic        counter0_OUT,
   input  logic        irq_en,
   input  logic        irq_ack,
   output logic        irq,
   output logic        busy,
   output logic        owner
);

   typedef enum logic [2:0] {StIdle, StCtrl, StLoad, StSettle, StDone} state_e;

   state_e state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        owner_q, owner_d;
   logic [23:0] shadow_q, shadow_d;
   logic [1:0]  req_ch_q, req_ch_d;
   logic [31:0] req_val_q, req_val_d;
   logic        we_q, we_d;
   logic [1:0]  ch_q, ch_d;
   logic [31:0] val_q, val_d;
   logic        cpu_done_q, cpu_done_d;
   logic        aux_done_q, aux_done_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic        sync_prev_q;
   logic        irq_q, irq_d;

   logic        gnt_any, gnt_aux;
   logic [1:0]  sel_ch, sel_mode;
   logic [31:0] sel_val;
   logic [23:0] shadow_new;
   logic        rise;

   // Round-robin: on contention the requester that was not granted last wins.
   always_comb begin
      gnt_any    = cpu_req | aux_req;
      gnt_aux    = aux_req & (~cpu_req | ~owner_q);
      sel_ch     = gnt_aux ? aux_ch   : cpu_ch;
      sel_mode   = gnt_aux ? aux_mode : cpu_mode;
      sel_val    = gnt_aux ? aux_val  : cpu_val;
      shadow_new = shadow_q;
      if (sel_ch == 2'd3) begin
         shadow_new = sel_val[23:0];
      end else begin
         for (int c = 0; c < 3; c++) begin
            if (sel_ch == 2'(c)) shadow_new[8*c+1 +: 2] = sel_mode;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      owner_d   = owner_q;
      shadow_d  = shadow_q;
      req_ch_d  = req_ch_q;
      req_val_d = req_val_q;
      unique case (state_q)
         StIdle: begin
            if (gnt_any) begin
               state_d   = StCtrl;
               owner_d   = gnt_aux;
               shadow_d  = shadow_new;
               req_ch_d  = sel_ch;
               req_val_d = sel_val;
            end
         end
         StCtrl:   state_d = (req_ch_q == 2'd3) ? StDone : StLoad;
         StLoad: begin
            state_d = StSettle;
            cnt_d   = 4'(SETTLE_CYC - 1);
         end
         StSettle: begin
            if (cnt_q == 4'd0) state_d = StDone;
            else               cnt_d   = cnt_q - 4'd1;
         end
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Outputs are decoded from the next state so the registered port lines up with the state.
   always_comb begin
      we_d       = 1'b0;
      ch_d       = 2'd0;
      val_d      = 32'd0;
      cpu_done_d = 1'b0;
      aux_done_d = 1'b0;
      unique case (state_d)
         StCtrl: begin
            we_d  = 1'b1;
            ch_d  = 2'd3;
            val_d = {8'h00, shadow_d};
         end
         StLoad: begin
            we_d  = 1'b1;
            ch_d  = req_ch_q;
            val_d = req_val_q;
         end
         StDone: begin
            cpu_done_d = ~owner_q;
            aux_done_d = owner_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      rise  = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
      irq_d = irq_ack ? (rise & irq_en) : (irq_q | (rise & irq_en));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         cnt_q       <= 4'd0;
         owner_q     <= 1'b1;
         shadow_q    <= 24'h0;
         req_ch_q    <= 2'd0;
         req_val_q   <= 32'd0;
         we_q        <= 1'b0;
         ch_q        <= 2'd0;
         val_q       <= 32'd0;
         cpu_done_q  <= 1'b0;
         aux_done_q  <= 1'b0;
         sync_q      <= '0;
         sync_prev_q <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         owner_q     <= owner_d;
         shadow_q    <= shadow_d;
         req_ch_q    <= req_ch_d;
         req_val_q   <= req_val_d;
         we_q        <= we_d;
         ch_q        <= ch_d;
         val_q       <= val_d;
         cpu_done_q  <= cpu_done_d;
         aux_done_q  <= aux_done_d;
         sync_q      <= {sync_q[SYNC_STAGES-2:0], counter0_OUT};
         sync_prev_q <= sync_q[SYNC_STAGES-1];
         irq_q       <= irq_d;
      end
   end

   assign counter_we  = we_q;
   assign counter_ch  = ch_q;
   assign counter_val = val_q;
   assign cpu_done    = cpu_done_q;
   assign aux_done    = aux_done_q;
   assign irq         = irq_q;
   assign busy        = (state_q != StIdle);
   assign owner       = owner_q;

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: vector table, hand-written corner sequences, then random traffic
// against a timeline-based reference model.
module tb_counter_sched;

   localparam int unsigned SETTLE = 4;
   localparam int unsigned SYNC   = 2;
   localparam int          NRAND  = 2000;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, aux_req;
   logic [1:0]  cpu_ch, cpu_mode, aux_ch, aux_mode;
   logic [31:0] cpu_val, aux_val;
   logic        cpu_done, aux_done;
   logic        counter_we;
   logic [1:0]  counter_ch;
   logic [31:0] counter_val;
   logic        counter0_OUT, irq_en, irq_ack, irq, busy, owner;

   always #5 clk = ~clk;

   counter_sched #(.SETTLE_CYC(SETTLE), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_ch(cpu_ch), .cpu_mode(cpu_mode), .cpu_val(cpu_val),
      .cpu_done(cpu_done),
      .aux_req(aux_req), .aux_ch(aux_ch), .aux_mode(aux_mode), .aux_val(aux_val),
      .aux_done(aux_done),
      .counter_we(counter_we), .counter_ch(counter_ch), .counter_val(counter_val),
      .counter0_OUT(counter0_OUT), .irq_en(irq_en), .irq_ack(irq_ack), .irq(irq),
      .busy(busy), .owner(owner)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_req(input bit who, input logic r, input logic [1:0] ch,
                          input logic [1:0] mode, input logic [31:0] val);
      if (who) begin
         aux_req = r; aux_ch = ch; aux_mode = mode; aux_val = val;
      end else begin
         cpu_req = r; cpu_ch = ch; cpu_mode = mode; cpu_val = val;
      end
   endtask

   function automatic logic done_of(input bit who);
      return who ? aux_done : cpu_done;
   endfunction

   task automatic do_reset();
      set_req(0, 0, 0, 0, 0);
      set_req(1, 0, 0, 0, 0);
      counter0_OUT = 0; irq_en = 0; irq_ack = 0;
      rst = 0;
      repeat (3) @(negedge clk);
      rst = 1;
   endtask

   task automatic wait_done(input bit who, input int bound, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!done_of(who) && cyc < bound);
      if (!done_of(who)) cyc = -1;
   endtask

   task automatic wait_ctrl(input int bound, output int cyc, output logic [31:0] val);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(counter_we && counter_ch == 2'd3) && cyc < bound);
      val = counter_val;
      if (!(counter_we && counter_ch == 2'd3)) cyc = -1;
   endtask

   typedef struct {
      bit          who;
      logic [1:0]  ch;
      logic [1:0]  mode;
      logic [31:0] val;
      logic [23:0] ctrl;   // expected control word written in the CTRL cycle
      int          lat;    // negedges from raising req to seeing done
   } vec_t;

   vec_t vecs[6];

   // Reference model state for the random phase (indexed by clock edge after reset)
   logic        exp_we   [0:NRAND+15];
   logic [1:0]  exp_ch   [0:NRAND+15];
   logic [31:0] exp_val  [0:NRAND+15];
   logic        exp_cdone[0:NRAND+15];
   logic        exp_adone[0:NRAND+15];
   logic        exp_busy [0:NRAND+15];
   logic        c0_hist  [0:NRAND+15];

   function automatic logic hist_at(input int i);
      return (i < 0) ? 1'b0 : c0_hist[i];
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat, cyc, seen;
      logic [31:0] v;
      vec_t        t;

      vecs[0] = '{0, 2'd1, 2'd2, 32'h0000_1234, 24'h000400, 7};
      vecs[1] = '{1, 2'd0, 2'd3, 32'h0000_00A5, 24'h000406, 7};
      vecs[2] = '{1, 2'd3, 2'd0, 32'hFFAB_CDEF, 24'hABCDEF, 2};
      vecs[3] = '{0, 2'd2, 2'd2, 32'h0000_0005, 24'hADCDEF, 7};
      vecs[4] = '{0, 2'd1, 2'd0, 32'h1111_2222, 24'hADC9EF, 7};
      vecs[5] = '{1, 2'd0, 2'd1, 32'hFFFF_FFFF, 24'hADC9EB, 7};

      // Reset state
      do_reset();
      @(negedge clk);
      chk("rst_we", counter_we, 0);
      chk("rst_ch", counter_ch, 0);
      chk("rst_val", counter_val, 0);
      chk("rst_cpu_done", cpu_done, 0);
      chk("rst_aux_done", aux_done, 0);
      chk("rst_irq", irq, 0);
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, 1);

      // Single requests from IDLE; shadow accumulates across vectors
      for (int i = 0; i < 6; i++) begin
         t = vecs[i];
         set_req(t.who, 1, t.ch, t.mode, t.val);
         @(negedge clk);
         lat = 1;
         chk($sformatf("v%0d_ctrl_we", i), counter_we, 1);
         chk($sformatf("v%0d_ctrl_ch", i), counter_ch, 3);
         chk($sformatf("v%0d_ctrl_val", i), counter_val, {8'h00, t.ctrl});
         chk($sformatf("v%0d_owner", i), owner, t.who);
         chk($sformatf("v%0d_busy", i), busy, 1);
         // Data changes after grant must not matter
         set_req(t.who, 1, ~t.ch, ~t.mode, ~t.val);
         if (t.ch != 2'd3) begin
            @(negedge clk);
            lat++;
            chk($sformatf("v%0d_load_we", i), counter_we, 1);
            chk($sformatf("v%0d_load_ch", i), counter_ch, t.ch);
            chk($sformatf("v%0d_load_val", i), counter_val, t.val);
         end
         while (!done_of(t.who) && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         chk($sformatf("v%0d_done_lat", i), lat, t.lat);
         set_req(t.who, 0, 0, 0, 0);
         @(negedge clk);
         chk($sformatf("v%0d_done_pulse", i), done_of(t.who), 0);
         @(negedge clk);
         chk($sformatf("v%0d_idle", i), busy, 0);
      end

      // Both requesters at once after reset: CPU first, then aux keeps CPU's mode bits
      do_reset();
      set_req(0, 1, 2'd1, 2'd2, 32'h0000_1234);
      set_req(1, 1, 2'd0, 2'd3, 32'h0000_00A5);
      @(negedge clk);
      chk("rr_first_val", counter_val, 32'h0000_0400);
      chk("rr_first_owner", owner, 0);
      wait_done(0, 20, cyc);
      chk("rr_cpu_done_lat", cyc, 6);
      chk("rr_aux_not_done", aux_done, 0);
      set_req(0, 0, 0, 0, 0);
      wait_ctrl(10, cyc, v);
      chk("rr_gap", cyc, 2);
      chk("rr_second_val", v, 32'h0000_0406);
      chk("rr_second_owner", owner, 1);
      wait_done(1, 20, cyc);
      chk("rr_aux_done_lat", cyc, 6);
      set_req(1, 0, 0, 0, 0);
      @(negedge clk);

      // Reset during LOAD aborts the sequence
      do_reset();
      set_req(0, 1, 2'd2, 2'd1, 32'h0000_CAFE);
      @(negedge clk);
      chk("abort_ctrl_val", counter_val, 32'h0002_0000);
      @(negedge clk);
      chk("abort_load_ch", counter_ch, 2);
      rst = 0;
      @(negedge clk);
      chk("abort_we", counter_we, 0);
      chk("abort_busy", busy, 0);
      set_req(0, 0, 0, 0, 0);
      rst = 1;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (cpu_done || aux_done || counter_we) seen++;
      end
      chk("abort_quiet", seen, 0);
      set_req(1, 1, 2'd1, 2'd1, 32'h0000_0009);
      wait_ctrl(5, cyc, v);
      chk("restart_ctrl_lat", cyc, 1);
      chk("restart_ctrl_val", v, 32'h0000_0200);
      wait_done(1, 20, cyc);
      chk("restart_done_lat", cyc, 6);
      set_req(1, 0, 0, 0, 0);
      @(negedge clk);

      // irq: latency, ack, rise coincident with ack, masking
      irq_en = 1;
      counter0_OUT = 1;
      repeat (2) @(negedge clk);
      chk("irq_early", irq, 0);
      @(negedge clk);
      chk("irq_set", irq, 1);
      irq_ack = 1;
      @(negedge clk);
      chk("irq_ack_clr", irq, 0);
      irq_ack = 0;
      counter0_OUT = 0;
      repeat (4) @(negedge clk);
      counter0_OUT = 1;
      repeat (3) @(negedge clk);
      chk("irq_set2", irq, 1);
      counter0_OUT = 0;
      repeat (4) @(negedge clk);
      chk("irq_sticky", irq, 1);
      counter0_OUT = 1;
      repeat (2) @(negedge clk);
      irq_ack = 1;
      @(negedge clk);
      chk("irq_rise_beats_ack", irq, 1);
      @(negedge clk);
      chk("irq_ack_after", irq, 0);
      irq_ack = 0;
      irq_en = 0;
      counter0_OUT = 0;
      repeat (4) @(negedge clk);
      counter0_OUT = 1;
      repeat (5) @(negedge clk);
      chk("irq_masked", irq, 0);

      // Random traffic against the timeline model
      begin
         int          free_at, done_at;
         bit          m_owner, m_irq, who, pend_c, pend_a, rise;
         logic [23:0] m_shadow;
         logic [1:0]  g_ch, g_mode;
         logic [31:0] g_val;

         for (int i = 0; i <= NRAND + 15; i++) begin
            exp_we[i] = 0; exp_ch[i] = 0; exp_val[i] = 0;
            exp_cdone[i] = 0; exp_adone[i] = 0; exp_busy[i] = 0; c0_hist[i] = 0;
         end
         do_reset();
         free_at = 0; m_owner = 1; m_irq = 0; m_shadow = 24'h0;
         pend_c = 0; pend_a = 0;

         for (int n = 0; n < NRAND; n++) begin
            if (n > 0 && exp_cdone[n-1]) pend_c = 0;
            if (n > 0 && exp_adone[n-1]) pend_a = 0;
            if (!pend_c && $urandom_range(0, 3) == 0) pend_c = 1;
            if (!pend_a && $urandom_range(0, 3) == 0) pend_a = 1;
            set_req(0, pend_c, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom);
            set_req(1, pend_a, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom);
            if ($urandom_range(0, 7) == 0) counter0_OUT = ~counter0_OUT;
            irq_en  = ($urandom_range(0, 3) != 0);
            irq_ack = ($urandom_range(0, 5) == 0);
            c0_hist[n] = counter0_OUT;

            if (n >= free_at && (cpu_req || aux_req)) begin
               who     = (cpu_req && aux_req) ? ~m_owner : aux_req;
               m_owner = who;
               g_ch    = who ? aux_ch   : cpu_ch;
               g_mode  = who ? aux_mode : cpu_mode;
               g_val   = who ? aux_val  : cpu_val;
               if (g_ch == 2'd3) m_shadow = g_val[23:0];
               else              m_shadow[8*int'(g_ch)+1 +: 2] = g_mode;
               exp_we[n] = 1; exp_ch[n] = 3; exp_val[n] = {8'h00, m_shadow};
               if (g_ch == 2'd3) begin
                  done_at = n + 1;
               end else begin
                  exp_we[n+1] = 1; exp_ch[n+1] = g_ch; exp_val[n+1] = g_val;
                  done_at = n + 2 + SETTLE;
               end
               if (who) exp_adone[done_at] = 1;
               else     exp_cdone[done_at] = 1;
               for (int k = n; k <= done_at; k++) exp_busy[k] = 1;
               free_at = done_at + 2;
            end

            rise  = hist_at(n - SYNC) & ~hist_at(n - SYNC - 1);
            m_irq = irq_ack ? (rise & irq_en) : (m_irq | (rise & irq_en));

            @(negedge clk);
            chk($sformatf("rnd%0d_we", n), counter_we, exp_we[n]);
            if (exp_we[n]) begin
               chk($sformatf("rnd%0d_ch", n), counter_ch, exp_ch[n]);
               chk($sformatf("rnd%0d_val", n), counter_val, exp_val[n]);
            end
            chk($sformatf("rnd%0d_cpu_done", n), cpu_done, exp_cdone[n]);
            chk($sformatf("rnd%0d_aux_done", n), aux_done, exp_adone[n]);
            chk($sformatf("rnd%0d_busy", n), busy, exp_busy[n]);
            chk($sformatf("rnd%0d_owner", n), owner, m_owner);
            chk($sformatf("rnd%0d_irq", n), irq, m_irq);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
